// File: rtl/deser_pkg.sv
// Shared types and helpers for the lane deserializer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package deser_pkg;

   // Assembly-side state: IDLE means no partial frame is held.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Counter width able to hold 0..MSG_SIZE.
   function automatic int cnt_w(input int msg_size);
      return $clog2(msg_size) + 1;
   endfunction

   function automatic bit lanes_legal(input int lanes);
      return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8);
   endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// Frame shift register with selectable bit order.
// Latency: 1 cycle per lane group; sr_d exposes the value including this cycle's lanes.
// Backpressure: none; shifts whenever shift_en is high.
// Ports: clk, rst_n; shift_en (capture strobe); lanes_in (LANES bits);
//        sr_q (registered contents); sr_d (next contents, used to load a completed frame).
module deser_shift_reg #(
   parameter int MSG_SIZE  = 64,
   parameter int LANES     = 1,
   parameter int LSB_FIRST = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                shift_en,
   input  logic [LANES-1:0]    lanes_in,
   output logic [MSG_SIZE-1:0] sr_q,
   output logic [MSG_SIZE-1:0] sr_d
);

   always_comb begin
      sr_d = sr_q;
      if (shift_en) begin
         if (LSB_FIRST != 0) begin
            // Earliest bits migrate towards bit 0; lane 0 is the earlier bit.
            sr_d = {lanes_in, sr_q[MSG_SIZE-1:LANES]};
         end else begin
            // Earliest bits migrate towards the MSB; lane LANES-1 is the earlier bit.
            sr_d = {sr_q[MSG_SIZE-LANES-1:0], lanes_in};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

endmodule

// File: rtl/lane_deserializer.sv
// Multi-lane serial-to-parallel converter with a single holding register on a valid/ready port.
// Latency: frame visible on oData_out the cycle after its last lane group is captured.
// Backpressure: a frame completing while the holding register is full and not being read is
//               dropped and flagged by a one-cycle oOverflow pulse; capture itself never stalls.
// Ports: clk, rst_n; ena (capture enable); iData_in/iData_flag (lane data + qualifier);
//        iReady (downstream accept); oBit_counter, oBusy (partial frame status);
//        oData_out/oValid (completed frame); oOverflow, oAbort (event pulses).
module lane_deserializer
   import deser_pkg::*;
#(
   parameter int MSG_SIZE     = 64,
   parameter int LANES        = 1,
   parameter int LSB_FIRST    = 0,
   parameter int ABORT_ON_GAP = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ena,
   input  logic [LANES-1:0]             iData_in,
   input  logic                         iData_flag,
   input  logic                         iReady,
   output logic [cnt_w(MSG_SIZE)-1:0]   oBit_counter,
   output logic [MSG_SIZE-1:0]          oData_out,
   output logic                         oValid,
   output logic                         oBusy,
   output logic                         oOverflow,
   output logic                         oAbort
);

   localparam int CW = cnt_w(MSG_SIZE);

   if (!lanes_legal(LANES)) begin : g_bad_lanes
      $error("lane_deserializer: LANES must be 1, 2, 4 or 8");
   end
   if ((MSG_SIZE % LANES) != 0 || MSG_SIZE < 2 * LANES) begin : g_bad_size
      $error("lane_deserializer: MSG_SIZE must be a multiple of LANES and >= 2*LANES");
   end

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [MSG_SIZE-1:0] data_q, data_d;
   logic                valid_q, valid_d;
   logic                ovf_q, ovf_d;
   logic                abort_q, abort_d;
   logic [MSG_SIZE-1:0] sr_q, sr_d;

   logic cap, last, gap, out_free;

   assign cap      = ena & iData_flag;
   assign last     = cap & (cnt_q == CW'(MSG_SIZE - LANES));
   // ena low is a pure freeze, so only an enabled cycle without flag counts as a gap.
   assign gap      = (ABORT_ON_GAP != 0) & ena & ~iData_flag & (cnt_q != '0);
   // The holding register can take a new frame if empty or emptied on this same edge.
   assign out_free = ~valid_q | iReady;

   deser_shift_reg #(
      .MSG_SIZE (MSG_SIZE),
      .LANES    (LANES),
      .LSB_FIRST(LSB_FIRST)
   ) u_sr (
      .clk     (clk),
      .rst_n   (rst_n),
      .shift_en(cap),
      .lanes_in(iData_in),
      .sr_q    (sr_q),
      .sr_d    (sr_d)
   );

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cap)         state_d = SHIFT;
         SHIFT:   if (last || gap) state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   // FSM: outputs (counter update); IDLE always holds a zero count.
   always_comb begin
      cnt_d = cnt_q;
      case (state_q)
         IDLE: cnt_d = cap ? CW'(LANES) : '0;
         SHIFT: begin
            if (last || gap) begin
               cnt_d = '0;
            end else if (cap) begin
               cnt_d = cnt_q + CW'(LANES);
            end
         end
         default: cnt_d = '0;
      endcase
   end

   // Output holding register and handshake; independent of ena.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovf_d   = 1'b0;
      abort_d = gap;
      if (last) begin
         if (out_free) begin
            data_d  = sr_d;
            valid_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (valid_q && iReady) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         abort_q <= abort_d;
      end
   end

   assign oBit_counter = cnt_q;
   assign oData_out    = data_q;
   assign oValid       = valid_q;
   assign oBusy        = (cnt_q != '0);
   assign oOverflow    = ovf_q;
   assign oAbort       = abort_q;

endmodule

// File: tb/tb_lane_deserializer.sv
// Bench for lane_deserializer: two instances (8-bit/1 lane/MSB first/abort, and
// 8-bit/2 lanes/LSB first/pause) share control inputs and are compared every cycle
// against a bit-list reference model, plus directed constant checks.
module tb_lane_deserializer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       flag = 1'b0;
   logic       rdy = 1'b0;
   logic       a_din = 1'b0;
   logic [1:0] b_din = 2'b00;

   logic [3:0] a_cnt, b_cnt;
   logic [7:0] a_data, b_data;
   logic       a_valid, a_busy, a_ovf, a_abort;
   logic       b_valid, b_busy, b_ovf, b_abort;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   lane_deserializer #(.MSG_SIZE(8), .LANES(1), .LSB_FIRST(0), .ABORT_ON_GAP(1)) u_a (
      .clk(clk), .rst_n(rst_n), .ena(ena), .iData_in(a_din), .iData_flag(flag),
      .iReady(rdy), .oBit_counter(a_cnt), .oData_out(a_data), .oValid(a_valid),
      .oBusy(a_busy), .oOverflow(a_ovf), .oAbort(a_abort));

   lane_deserializer #(.MSG_SIZE(8), .LANES(2), .LSB_FIRST(1), .ABORT_ON_GAP(0)) u_b (
      .clk(clk), .rst_n(rst_n), .ena(ena), .iData_in(b_din), .iData_flag(flag),
      .iReady(rdy), .oBit_counter(b_cnt), .oData_out(b_data), .oValid(b_valid),
      .oBusy(b_busy), .oOverflow(b_ovf), .oAbort(b_abort));

   // Reference model: per instance, the list of bits received in arrival order.
   int         lanes_p[2] = '{1, 2};
   bit         lsb_p[2]   = '{1'b0, 1'b1};
   bit         abt_p[2]   = '{1'b1, 1'b0};
   int         nb[2];
   bit         fbits[2][8];
   logic [7:0] mdata[2];
   bit         mvalid[2], movf[2], mab[2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         nb[k] = 0; mdata[k] = '0; mvalid[k] = 0; movf[k] = 0; mab[k] = 0;
      end
   endtask

   task automatic model_step(input int k, input logic [1:0] din);
      logic [7:0] frame;
      bit complete;
      int lane;
      frame = '0;
      complete = 0;
      movf[k] = 0;
      mab[k] = 0;
      if (ena && flag) begin
         for (int j = 0; j < lanes_p[k]; j++) begin
            lane = lsb_p[k] ? j : lanes_p[k] - 1 - j;
            fbits[k][nb[k]] = din[lane];
            nb[k]++;
         end
         if (nb[k] == 8) begin
            for (int i = 0; i < 8; i++) frame[lsb_p[k] ? i : 7 - i] = fbits[k][i];
            nb[k] = 0;
            complete = 1;
         end
      end else if (abt_p[k] && ena && nb[k] != 0) begin
         nb[k] = 0;
         mab[k] = 1;
      end
      if (complete) begin
         if (!mvalid[k] || rdy) begin
            mdata[k] = frame;
            mvalid[k] = 1;
         end else begin
            movf[k] = 1;
         end
      end else if (mvalid[k] && rdy) begin
         mvalid[k] = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic compare_all();
      chk("A.cnt",   8'(a_cnt),   8'(nb[0]));
      chk("A.data",  a_data,      mdata[0]);
      chk("A.valid", 8'(a_valid), 8'(mvalid[0]));
      chk("A.busy",  8'(a_busy),  8'(nb[0] != 0));
      chk("A.ovf",   8'(a_ovf),   8'(movf[0]));
      chk("A.abort", 8'(a_abort), 8'(mab[0]));
      chk("B.cnt",   8'(b_cnt),   8'(nb[1]));
      chk("B.data",  b_data,      mdata[1]);
      chk("B.valid", 8'(b_valid), 8'(mvalid[1]));
      chk("B.busy",  8'(b_busy),  8'(nb[1] != 0));
      chk("B.ovf",   8'(b_ovf),   8'(movf[1]));
      chk("B.abort", 8'(b_abort), 8'(mab[1]));
   endtask

   // Inputs are already set; advance one edge and compare.
   task automatic tick();
      if (!rst_n) begin
         model_reset();
      end else begin
         model_step(0, {1'b0, a_din});
         model_step(1, b_din);
      end
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic sync_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      compare_all();
      rst_n = 1'b1;
   endtask

   logic [7:0] pat;
   logic [1:0] b_seq[4] = '{2'b01, 2'b10, 2'b11, 2'b00};

   initial begin
      // Reset state
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;

      // 1 + 2: A gets 8'hA5 MSB first, B gets 01,10,11,00 LSB first (twice, second overflows)
      pat = 8'hA5;
      ena = 1; flag = 1; rdy = 0;
      for (int i = 0; i < 8; i++) begin
         a_din = pat[7 - i];
         b_din = b_seq[i % 4];
         tick();
         if (i < 7) chk("t1.A.cnt", 8'(a_cnt), 8'(i + 1));
         if (i == 3) begin
            chk("t2.B.data", b_data, 8'h39);
            chk("t2.B.valid", 8'(b_valid), 8'h01);
         end
      end
      chk("t1.A.data", a_data, 8'hA5);
      chk("t1.A.valid", 8'(a_valid), 8'h01);
      chk("t1.A.busy", 8'(a_busy), 8'h00);
      chk("t1.A.cnt0", 8'(a_cnt), 8'h00);
      chk("t3.B.ovf", 8'(b_ovf), 8'h01);

      // 3: backpressure, 8'h3C dropped, then accepted with iReady on completion edge
      pat = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         a_din = pat[7 - i];
         b_din = 2'($urandom);
         tick();
      end
      chk("t3.A.ovf", 8'(a_ovf), 8'h01);
      chk("t3.A.keep", a_data, 8'hA5);
      flag = 0;
      tick();
      chk("t3.A.ovf_end", 8'(a_ovf), 8'h00);
      flag = 1;
      for (int i = 0; i < 8; i++) begin
         a_din = pat[7 - i];
         b_din = 2'($urandom);
         rdy = (i == 7);
         tick();
      end
      chk("t3.A.load", a_data, 8'h3C);
      chk("t3.A.noovf", 8'(a_ovf), 8'h00);

      // 4: gap after 3 caps; A aborts, B pauses
      sync_reset();
      rdy = 1; a_din = 1; b_din = 2'b11;
      repeat (3) tick();
      flag = 0;
      tick();
      chk("t4.A.abort", 8'(a_abort), 8'h01);
      chk("t4.A.cnt", 8'(a_cnt), 8'h00);
      chk("t4.B.cnt", 8'(b_cnt), 8'h06);
      chk("t4.B.noabort", 8'(b_abort), 8'h00);
      flag = 1;
      tick();
      chk("t4.B.frame", b_data, 8'hFF);
      repeat (7) tick();
      chk("t4.A.frame", a_data, 8'hFF);
      chk("t4.A.valid", 8'(a_valid), 8'h01);

      // 5: freeze mid-frame while the pending frame is consumed
      rdy = 0; a_din = 0;
      repeat (3) tick();
      ena = 0; rdy = 1;
      for (int i = 0; i < 4; i++) begin
         flag = i[0];
         tick();
      end
      chk("t5.A.cnt", 8'(a_cnt), 8'h03);
      chk("t5.A.noabort", 8'(a_abort), 8'h00);
      chk("t5.A.consumed", 8'(a_valid), 8'h00);
      ena = 1; flag = 1; rdy = 0;
      repeat (5) tick();

      // 6: asynchronous reset mid-frame with a frame pending
      repeat (5) tick();
      chk("t6.A.cnt5", 8'(a_cnt), 8'h05);
      chk("t6.A.pending", 8'(a_valid), 8'h01);
      rst_n = 0;
      #2;
      model_reset();
      compare_all();
      tick();
      rst_n = 1;
      pat = 8'h5A;
      for (int i = 0; i < 8; i++) begin
         a_din = pat[7 - i];
         tick();
      end
      chk("t6.A.clean", a_data, 8'h5A);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         ena   = ($urandom_range(0, 9) != 0);
         flag  = ($urandom_range(0, 4) != 0);
         rdy   = $urandom_range(0, 1) != 0;
         a_din = 1'($urandom);
         b_din = 2'($urandom);
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
